// File: rtl/cfeb_rdout_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfeb_rdout_sched_if : handshake bundle between header builder, L1A checker
//                       and the CFEB readout scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
interface cfeb_rdout_sched_if #(
  parameter int NCFEB = 7
);
  logic             header_end;
  logic [NCFEB-1:0] act_mask;
  logic             act_chk;
  logic [NCFEB-1:0] fifo_mt;
  logic             done_ce;
  logic             clr_done;
  logic [NCFEB-1:0] sel;
  logic             cfeb_act;
  logic             go;
  logic             eoe;
  logic             timeout;
  logic [NCFEB-1:0] err_mask;
  logic             busy;

  modport slave (
    input  header_end, act_mask, act_chk, fifo_mt, done_ce, clr_done,
    output sel, cfeb_act, go, eoe, timeout, err_mask, busy
  );

  modport master (
    output header_end, act_mask, act_chk, fifo_mt, done_ce, clr_done,
    input  sel, cfeb_act, go, eoe, timeout, err_mask, busy
  );
endinterface
`default_nettype wire

// File: rtl/cfeb_rdout_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfeb_rdout_sched : round-robin scheduler offering each active CFEB FIFO of
//                    an event to the L1A checker, with per-CFEB timeouts.
// Rev 1.0
// ---------------------------------------------------------------------------
module cfeb_rdout_sched #(
  parameter int NCFEB = 7,
  parameter int TMO   = 255
) (
  input  wire logic          clk,
  input  wire logic          rst,
  cfeb_rdout_sched_if.slave  bus
);

  localparam int                 c_PTR_W = (NCFEB > 1) ? $clog2(NCFEB) : 1;
  localparam logic [c_PTR_W:0]   c_N     = (c_PTR_W+1)'(NCFEB);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NCFEB - 1);
  localparam logic [7:0]         c_TMO   = 8'(TMO);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ARB   = 4'd1,
    S_WACT  = 4'd2,
    S_OFFER = 4'd3,
    S_WDAT  = 4'd4,
    S_GO    = 4'd5,
    S_RUN   = 4'd6,
    S_FIN   = 4'd7,
    S_EOE   = 4'd8
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NCFEB-1:0]     r_pend;
  logic [NCFEB-1:0]     r_sel;
  logic [NCFEB-1:0]     r_err;
  logic                 r_timeout;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W-1:0]   r_gidx;
  logic [7:0]           r_tcnt;

  logic                 w_found;
  logic [c_PTR_W-1:0]   w_gnt;
  logic [c_PTR_W:0]     w_cand;
  logic                 w_mt;
  logic                 w_done;
  logic                 w_tmo;
  logic [c_PTR_W-1:0]   w_ptr_nxt;

  assign w_mt      = bus.fifo_mt[r_gidx];
  assign w_done    = bus.done_ce | bus.clr_done;
  assign w_tmo     = (r_tcnt == c_TMO);
  assign w_ptr_nxt = (r_gidx == c_LAST) ? '0 : r_gidx + 1'b1;

  // First pending CFEB at or above the pointer, wrapping past the last FIFO.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_ptr;
    w_cand  = '0;
    for (int i = 0; i < NCFEB; i++) begin
      w_cand = {1'b0, r_ptr} + (c_PTR_W+1)'(i);
      if (w_cand >= c_N) begin
        w_cand = w_cand - c_N;
      end
      if (!w_found && r_pend[w_cand[c_PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_cand[c_PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.header_end) w_state_nxt = S_ARB;
      S_ARB:   w_state_nxt = w_found ? S_WACT : S_FIN;
      S_WACT:  if (bus.act_chk) w_state_nxt = S_OFFER;
      S_OFFER: w_state_nxt = S_WDAT;
      S_WDAT:  if (!w_mt || w_tmo) w_state_nxt = S_GO;
      S_GO:    w_state_nxt = S_RUN;
      S_RUN:   if (w_done || w_tmo) w_state_nxt = S_ARB;
      S_FIN:   if (bus.act_chk) w_state_nxt = S_EOE;
      S_EOE:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend    <= '0;
      r_sel     <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_tcnt    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.header_end) begin
            r_pend <= bus.act_mask;
            r_err  <= '0;
          end
        end
        S_ARB: begin
          if (w_found) begin
            r_gidx <= w_gnt;
            r_sel  <= {{(NCFEB-1){1'b0}}, 1'b1} << w_gnt;
          end
        end
        S_OFFER, S_GO: r_tcnt <= '0;
        S_WDAT: begin
          if (w_mt) begin
            if (w_tmo) begin
              r_err[r_gidx] <= 1'b1;
              r_timeout     <= 1'b1;
            end else begin
              r_tcnt <= r_tcnt + 8'd1;
            end
          end
        end
        S_RUN: begin
          // Completion takes priority over a timeout on the same cycle.
          if (w_done || w_tmo) begin
            r_pend[r_gidx] <= 1'b0;
            r_ptr          <= w_ptr_nxt;
            r_sel          <= '0;
            if (!w_done) begin
              r_err[r_gidx] <= 1'b1;
              r_timeout     <= 1'b1;
            end
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sel      = r_sel;
  assign bus.err_mask = r_err;
  assign bus.timeout  = r_timeout;
  assign bus.cfeb_act = (r_state == S_OFFER);
  assign bus.go       = (r_state == S_GO);
  assign bus.eoe      = (r_state == S_EOE);
  assign bus.busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cfeb_rdout_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cfeb_rdout_sched : directed self-checking bench for cfeb_rdout_sched.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cfeb_rdout_sched;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   n_act, n_go, n_eoe, n_tmo;

  cfeb_rdout_sched_if #(.NCFEB(7)) bus ();

  cfeb_rdout_sched #(.NCFEB(7), .TMO(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cfeb_act) n_act++;
    if (bus.go)       n_go++;
    if (bus.eoe)      n_eoe++;
    if (bus.timeout)  n_tmo++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.cfeb_act;
      1:       return bus.go;
      2:       return bus.eoe;
      default: return bus.timeout;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int maxc, input string tag, output int n);
    n = 0;
    while (!sig(which) && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(sig(which)), 32'd1);
  endtask

  task automatic start_event(input logic [6:0] mask, input string tag);
    bus.act_mask   = mask;
    bus.header_end = 1'b1;
    tick();
    bus.header_end = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  // One grant: offer, GO with data present, completion a few cycles into RUN.
  task automatic serve(input logic [6:0] exp_sel, input bit use_clr, input string tag);
    int n;
    wait_sig(0, 12, {tag, "_act"}, n);
    chk({tag, "_sel"}, 32'(bus.sel), 32'(exp_sel));
    wait_sig(1, 12, {tag, "_go"}, n);
    chk({tag, "_go_lat"}, 32'(n), 32'd2);
    tick();
    tick();
    if (use_clr) bus.clr_done = 1'b1;
    else         bus.done_ce  = 1'b1;
    tick();
    bus.done_ce  = 1'b0;
    bus.clr_done = 1'b0;
    chk({tag, "_sel_rel"}, 32'(bus.sel), 32'd0);
  endtask

  task automatic finish_event(input string tag);
    int n;
    wait_sig(2, 12, {tag, "_eoe"}, n);
    tick();
    chk({tag, "_eoe_1cyc"}, 32'(bus.eoe), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n, c0, a0, g0, e0, t0;
    n_vec = 0; n_err = 0; cyc = 0;
    n_act = 0; n_go = 0; n_eoe = 0; n_tmo = 0;
    rst            = 1'b1;
    bus.header_end = 1'b0;
    bus.act_mask   = '0;
    bus.act_chk    = 1'b1;
    bus.fifo_mt    = '0;
    bus.done_ce    = 1'b0;
    bus.clr_done   = 1'b0;
    tick(); tick(); tick();
    chk("rst_sel",  32'(bus.sel),      32'd0);
    chk("rst_err",  32'(bus.err_mask), 32'd0);
    chk("rst_strb", 32'({bus.cfeb_act, bus.go, bus.eoe, bus.timeout}), 32'd0);
    chk("rst_busy", 32'(bus.busy),     32'd0);
    rst = 1'b0;
    tick();

    // Two CFEBs from pointer 0.
    a0 = n_act; g0 = n_go; e0 = n_eoe;
    start_event(7'b0000101, "A");
    tick();
    chk("A_sel_wact", 32'(bus.sel), 32'd1);
    serve(7'b0000001, 1'b0, "A1");
    serve(7'b0000100, 1'b0, "A2");
    wait_sig(2, 12, "A_eoe", n);
    chk("A_eoe_lat", 32'(n), 32'd2);
    tick();
    chk("A_nact", 32'(n_act - a0), 32'd2);
    chk("A_ngo",  32'(n_go - g0),  32'd2);
    chk("A_neoe", 32'(n_eoe - e0), 32'd1);
    chk("A_err",  32'(bus.err_mask), 32'd0);

    // Pointer now 3: order bit5, bit1, bit2.
    start_event(7'b0100110, "B");
    serve(7'b0100000, 1'b1, "B1");
    serve(7'b0000010, 1'b1, "B2");
    serve(7'b0000100, 1'b0, "B3");
    finish_event("B");

    // Empty mask.
    g0 = n_go;
    start_event(7'b0000000, "C");
    wait_sig(2, 12, "C_eoe", n);
    chk("C_eoe_lat", 32'(n), 32'd2);
    tick();
    chk("C_ngo", 32'(n_go - g0), 32'd0);

    // Data never arrives: WDAT timeout, GO anyway; pointer 3 wraps to bit0.
    bus.fifo_mt = 7'h7f;
    start_event(7'b0000001, "D");
    wait_sig(0, 12, "D_act", n);
    c0 = cyc;
    wait_sig(1, 300, "D_go", n);
    chk("D_go_lat", 32'(cyc - c0), 32'd257);
    chk("D_tmo",    32'(bus.timeout),  32'd1);
    chk("D_err",    32'(bus.err_mask), 32'd1);
    tick();
    chk("D_tmo_1cyc", 32'(bus.timeout), 32'd0);
    bus.fifo_mt = '0;
    tick();
    bus.done_ce = 1'b1;
    tick();
    bus.done_ce = 1'b0;
    chk("D_sel_rel", 32'(bus.sel), 32'd0);
    finish_event("D");
    chk("D_err_hold", 32'(bus.err_mask), 32'd1);

    // Completion coincides with RUN timeout; HEADER_END while busy ignored.
    g0 = n_go; t0 = n_tmo; e0 = n_eoe;
    start_event(7'b0000010, "E");
    chk("E_err_clr", 32'(bus.err_mask), 32'd0);
    wait_sig(1, 12, "E_go", n);
    c0 = cyc;
    bus.act_mask   = 7'h7f;
    bus.header_end = 1'b1;
    tick();
    bus.header_end = 1'b0;
    while (cyc < c0 + 256) tick();
    bus.done_ce = 1'b1;
    tick();
    bus.done_ce = 1'b0;
    chk("E_tmo", 32'(bus.timeout),  32'd0);
    chk("E_err", 32'(bus.err_mask), 32'd0);
    chk("E_sel", 32'(bus.sel),      32'd0);
    finish_event("E");
    tick(); tick(); tick();
    chk("E_still_idle", 32'(bus.busy),         32'd0);
    chk("E_ngo",        32'(n_go - g0),       32'd1);
    chk("E_neoe",       32'(n_eoe - e0),      32'd1);
    chk("E_ntmo",       32'(n_tmo - t0),      32'd0);

    // Checker never completes: RUN timeout releases the grant.
    start_event(7'b0000100, "F");
    wait_sig(1, 12, "F_go", n);
    c0 = cyc;
    wait_sig(3, 300, "F_tmo", n);
    chk("F_tmo_lat", 32'(cyc - c0),    32'd257);
    chk("F_err",     32'(bus.err_mask), 32'd4);
    chk("F_sel",     32'(bus.sel),      32'd0);
    tick();
    chk("F_tmo_1cyc", 32'(bus.timeout), 32'd0);
    finish_event("F");

    // Reset in RUN, then a fresh event starts from pointer 0.
    start_event(7'b0000001, "G");
    wait_sig(1, 12, "G_go", n);
    tick();
    rst = 1'b1;
    tick();
    chk("G_rst_sel",  32'(bus.sel),      32'd0);
    chk("G_rst_err",  32'(bus.err_mask), 32'd0);
    chk("G_rst_strb", 32'({bus.cfeb_act, bus.go, bus.eoe, bus.timeout}), 32'd0);
    chk("G_rst_busy", 32'(bus.busy),     32'd0);
    rst = 1'b0;
    start_event(7'b0001001, "G2");
    tick();
    chk("G2_sel_wact", 32'(bus.sel), 32'd1);
    serve(7'b0000001, 1'b0, "G2a");
    serve(7'b0001000, 1'b1, "G2b");
    finish_event("G2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
